// File: rtl/riscv_pkg.sv
// Shared RV32I types for the pipeline: ALU op, result-source and forward-select encodings,
// plus the ID/EX register layout used by the execute stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSlt  = 4'd5,
    AluSltu = 4'd6,
    AluSll  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9
  } aluOp_e;

  typedef enum logic [1:0] {
    ResultAlu = 2'b00,
    ResultMem = 2'b01,
    ResultPc4 = 2'b10
  } resultSrc_e;

  typedef enum logic [1:0] {
    FwdReg     = 2'b00,
    FwdResultW = 2'b01,
    FwdAluM    = 2'b10,
    FwdRsvd    = 2'b11
  } forward_e;

  // Everything here is cleared by a flush so the slot becomes a bubble.
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       jumpReg;
    logic       branch;
    logic       aluSrc;
    logic       inverseBrCond;
    logic       luiOp;
    resultSrc_e resultSrc;
    logic [3:0] aluControl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idExCtrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] pcPlus4;
  } idExData_t;

  // Reserved select 11 falls back to the register-file value.
  function automatic logic [XLEN-1:0] fwdSelect(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] regVal,
                                                input logic [XLEN-1:0] resultW,
                                                input logic [XLEN-1:0] aluResultM);
    logic [XLEN-1:0] res;
    case (forward_e'(sel))
      FwdResultW: res = resultW;
      FwdAluM:    res = aluResultM;
      default:    res = regVal;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU; reserved op codes yield zero.
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [3:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  logic [4:0] shamt;
  assign shamt = SrcB[4:0];

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      AluAdd:  ALUResult = SrcA + SrcB;
      AluSub:  ALUResult = SrcA - SrcB;
      AluAnd:  ALUResult = SrcA & SrcB;
      AluOr:   ALUResult = SrcA | SrcB;
      AluXor:  ALUResult = SrcA ^ SrcB;
      AluSlt:  ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      AluSltu: ALUResult = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      AluSll:  ALUResult = SrcA << shamt;
      AluSrl:  ALUResult = SrcA >> shamt;
      AluSra:  ALUResult = $unsigned($signed(SrcA) >>> shamt);
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register with flush/stall, operand forwarding, ALU,
// and branch/jump resolution producing the fetch redirect.
module ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            FlushE,
  input  logic            StallE,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            JumpRegD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic            InverseBrCondD,
  input  logic            LUIOpD,
  input  logic [1:0]      ResultSrcD,
  input  logic [3:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE
);

  idExCtrl_t idExCtrlD, idExCtrlQ;
  idExData_t idExDataD, idExDataQ;

  always_comb begin
    idExCtrlD               = '0;
    idExCtrlD.regWrite      = RegWriteD;
    idExCtrlD.memWrite      = MemWriteD;
    idExCtrlD.jump          = JumpD;
    idExCtrlD.jumpReg       = JumpRegD;
    idExCtrlD.branch        = BranchD;
    idExCtrlD.aluSrc        = ALUSrcD;
    idExCtrlD.inverseBrCond = InverseBrCondD;
    idExCtrlD.luiOp         = LUIOpD;
    idExCtrlD.resultSrc     = resultSrc_e'(ResultSrcD);
    idExCtrlD.aluControl    = ALUControlD;
    idExCtrlD.rs1           = Rs1D;
    idExCtrlD.rs2           = Rs2D;
    idExCtrlD.rd            = RdD;

    idExDataD         = '0;
    idExDataD.rd1     = RD1D;
    idExDataD.rd2     = RD2D;
    idExDataD.pc      = PCD;
    idExDataD.immExt  = ImmExtD;
    idExDataD.pcPlus4 = PCPlus4D;
  end

  // A flush only has to kill control; data left behind is harmless in a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idExCtrlQ <= '0;
      idExDataQ <= '0;
    end else if (FlushE) begin
      idExCtrlQ <= '0;
    end else if (!StallE) begin
      idExCtrlQ <= idExCtrlD;
      idExDataQ <= idExDataD;
    end
  end

  logic [XLEN-1:0] fwdAE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            ZeroE;
  logic            branchTakenE;

  assign fwdAE      = fwdSelect(ForwardAE, idExDataQ.rd1, ResultW, ALUResultM);
  assign WriteDataE = fwdSelect(ForwardBE, idExDataQ.rd2, ResultW, ALUResultM);
  assign SrcAE      = idExCtrlQ.luiOp ? '0 : fwdAE;
  assign SrcBE      = idExCtrlQ.aluSrc ? idExDataQ.immExt : WriteDataE;

  alu u_alu (
    .SrcA       (SrcAE),
    .SrcB       (SrcBE),
    .ALUControl (idExCtrlQ.aluControl),
    .ALUResult  (ALUResultE),
    .Zero       (ZeroE)
  );

  // SUB drives beq/bne through Zero; SLT/SLTU give 1 when less-than, so inv selects lt vs ge.
  assign branchTakenE = idExCtrlQ.branch & (ZeroE ^ idExCtrlQ.inverseBrCond);
  assign PCSrcE       = idExCtrlQ.jump | branchTakenE;
  assign PCTargetE    = idExCtrlQ.jumpReg ? {ALUResultE[XLEN-1:1], 1'b0}
                                          : idExDataQ.pc + idExDataQ.immExt;

  assign RegWriteE  = idExCtrlQ.regWrite;
  assign MemWriteE  = idExCtrlQ.memWrite;
  assign ResultSrcE = idExCtrlQ.resultSrc;
  assign Rs1E       = idExCtrlQ.rs1;
  assign Rs2E       = idExCtrlQ.rs2;
  assign RdE        = idExCtrlQ.rd;
  assign PCPlus4E   = idExDataQ.pcPlus4;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes hand-computed expectations tagged with the
// cycle they apply to; a monitor pops and compares them on the falling edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FlushE, StallE;
  logic        RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, InverseBrCondD, LUIOpD;
  logic [1:0]  ResultSrcD;
  logic [3:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUResultM;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
  logic        PCSrcE;

  ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .FlushE         (FlushE),
    .StallE         (StallE),
    .RegWriteD      (RegWriteD),
    .MemWriteD      (MemWriteD),
    .JumpD          (JumpD),
    .JumpRegD       (JumpRegD),
    .BranchD        (BranchD),
    .ALUSrcD        (ALUSrcD),
    .InverseBrCondD (InverseBrCondD),
    .LUIOpD         (LUIOpD),
    .ResultSrcD     (ResultSrcD),
    .ALUControlD    (ALUControlD),
    .RD1D           (RD1D),
    .RD2D           (RD2D),
    .PCD            (PCD),
    .ImmExtD        (ImmExtD),
    .PCPlus4D       (PCPlus4D),
    .Rs1D           (Rs1D),
    .Rs2D           (Rs2D),
    .RdD            (RdD),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE),
    .ResultW        (ResultW),
    .ALUResultM     (ALUResultM),
    .RegWriteE      (RegWriteE),
    .MemWriteE      (MemWriteE),
    .ResultSrcE     (ResultSrcE),
    .Rs1E           (Rs1E),
    .Rs2E           (Rs2E),
    .RdE            (RdE),
    .ALUResultE     (ALUResultE),
    .WriteDataE     (WriteDataE),
    .PCPlus4E       (PCPlus4E),
    .PCTargetE      (PCTargetE),
    .PCSrcE         (PCSrcE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        regWrite, memWrite, jump, jumpReg, branch, aluSrc, inv, lui;
    logic [1:0]  resultSrc;
    logic [3:0]  aluCtl;
    logic [31:0] rd1, rd2, pc, imm, pcPlus4;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] resW, aluM;
  } vec_t;

  typedef struct {
    string       name;
    int          cyc;
    logic        chkCtl, chkAlu, chkTgt, chkWd;
    logic        regWrite, memWrite, pcSrc;
    logic [1:0]  resultSrc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] alu, tgt, wd, pcPlus4;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFail   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic exp_t mkE(input string n, input logic pcSrc, input logic chkAlu,
                               input logic [31:0] alu, input logic chkTgt,
                               input logic [31:0] tgt);
    exp_t e;
    e.name = n;  e.cyc = 0;
    e.chkCtl = 1'b0; e.chkAlu = chkAlu; e.chkTgt = chkTgt; e.chkWd = 1'b0;
    e.regWrite = 1'b0; e.memWrite = 1'b0; e.pcSrc = pcSrc; e.resultSrc = 2'b00;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.alu = alu; e.tgt = tgt; e.wd = '0; e.pcPlus4 = '0;
    return e;
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        e = expQ.pop_front();
        if (e.cyc < cyc) chk({e.name, ".late"}, 32'(cyc), 32'(e.cyc));
        chk({e.name, ".PCSrcE"}, 32'(PCSrcE), 32'(e.pcSrc));
        if (e.chkAlu) chk({e.name, ".ALUResultE"}, ALUResultE, e.alu);
        if (e.chkTgt) chk({e.name, ".PCTargetE"}, PCTargetE, e.tgt);
        if (e.chkWd) begin
          chk({e.name, ".WriteDataE"}, WriteDataE, e.wd);
          chk({e.name, ".PCPlus4E"}, PCPlus4E, e.pcPlus4);
        end
        if (e.chkCtl) begin
          chk({e.name, ".RegWriteE"}, 32'(RegWriteE), 32'(e.regWrite));
          chk({e.name, ".MemWriteE"}, 32'(MemWriteE), 32'(e.memWrite));
          chk({e.name, ".ResultSrcE"}, 32'(ResultSrcE), 32'(e.resultSrc));
          chk({e.name, ".Rs1E"}, 32'(Rs1E), 32'(e.rs1));
          chk({e.name, ".Rs2E"}, 32'(Rs2E), 32'(e.rs2));
          chk({e.name, ".RdE"}, 32'(RdE), 32'(e.rd));
        end
      end
    end
  end

  task automatic driveD(input vec_t v);
    RegWriteD = v.regWrite; MemWriteD = v.memWrite; JumpD = v.jump; JumpRegD = v.jumpReg;
    BranchD = v.branch; ALUSrcD = v.aluSrc; InverseBrCondD = v.inv; LUIOpD = v.lui;
    ResultSrcD = v.resultSrc; ALUControlD = v.aluCtl;
    RD1D = v.rd1; RD2D = v.rd2; PCD = v.pc; ImmExtD = v.imm; PCPlus4D = v.pcPlus4;
    Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
  endtask

  task automatic driveFwd(input vec_t v);
    ForwardAE = v.fwdA; ForwardBE = v.fwdB; ResultW = v.resW; ALUResultM = v.aluM;
  endtask

  // Called at posedge+1: D captured at the next edge, forwards applied in the E cycle.
  task automatic issue(input vec_t v, input exp_t e);
    driveD(v);
    e.cyc = cyc + 1;
    expQ.push_back(e);
    @(posedge clk); #1;
    driveFwd(v);
    driveD('0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    rst_n = 1'b0; FlushE = 1'b0; StallE = 1'b0;
    v = '0; driveFwd(v);
    v.regWrite = 1'b1; v.jump = 1'b1; v.rd = 5'd5; v.rs1 = 5'd6;
    driveD(v);

    // Reset held two edges, then checked on the first cycle after release.
    @(posedge clk); #1;
    e = mkE("rst_hold", 1'b0, 1'b1, 32'h0, 1'b1, 32'h0); e.chkCtl = 1'b1; e.cyc = cyc;
    expQ.push_back(e);
    @(posedge clk); #1;
    rst_n = 1'b1;
    e = mkE("rst_release", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0); e.chkCtl = 1'b1; e.cyc = cyc;
    expQ.push_back(e);
    driveD('0);
    @(posedge clk); #1;

    // beq taken
    v = '0; v.rd1 = 32'h10; v.rd2 = 32'h10; v.aluCtl = 4'd1; v.branch = 1'b1;
    v.pc = 32'h100; v.imm = 32'h20; v.rs1 = 5'd1; v.rs2 = 5'd2;
    issue(v, mkE("beq", 1'b1, 1'b1, 32'h0, 1'b1, 32'h120));
    // bne not taken
    v.inv = 1'b1;
    issue(v, mkE("bne", 1'b0, 1'b1, 32'h0, 1'b1, 32'h120));
    // blt signed taken
    v = '0; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'h1; v.aluCtl = 4'd5; v.branch = 1'b1;
    v.inv = 1'b1; v.pc = 32'h140; v.imm = 32'h8;
    issue(v, mkE("blt", 1'b1, 1'b1, 32'h1, 1'b1, 32'h148));
    // bltu same operands, not taken
    v.aluCtl = 4'd6;
    issue(v, mkE("bltu", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0));
    // jalr: target has bit 0 cleared
    v = '0; v.rd1 = 32'h1003; v.imm = 32'h4; v.aluSrc = 1'b1; v.jump = 1'b1; v.jumpReg = 1'b1;
    v.regWrite = 1'b1; v.resultSrc = 2'b10; v.rd = 5'd1; v.rs1 = 5'd7;
    v.pc = 32'h200; v.pcPlus4 = 32'h204;
    e = mkE("jalr", 1'b1, 1'b1, 32'h1007, 1'b1, 32'h1006);
    e.chkCtl = 1'b1; e.regWrite = 1'b1; e.resultSrc = 2'b10; e.rd = 5'd1; e.rs1 = 5'd7;
    e.chkWd = 1'b1; e.wd = 32'h0; e.pcPlus4 = 32'h204;
    issue(v, e);
    // jal: PC-relative target with negative offset
    v = '0; v.jump = 1'b1; v.pc = 32'h400; v.imm = 32'hFFFF_FFF0;
    issue(v, mkE("jal", 1'b1, 1'b0, 32'h0, 1'b1, 32'h3F0));
    // Forward A from ALUResultM
    v = '0; v.rd1 = 32'h1; v.imm = 32'h3; v.aluSrc = 1'b1; v.fwdA = 2'b10; v.aluM = 32'h7;
    issue(v, mkE("fwdA_M", 1'b0, 1'b1, 32'hA, 1'b0, 32'h0));
    // LUI zeroes SrcA regardless of the register value
    v = '0; v.lui = 1'b1; v.imm = 32'h1234_5000; v.aluSrc = 1'b1; v.rd1 = 32'hDEAD_BEEF;
    issue(v, mkE("lui", 1'b0, 1'b1, 32'h1234_5000, 1'b0, 32'h0));
    // Forward B from ResultW feeds both SrcB and WriteDataE
    v = '0; v.rd1 = 32'h5; v.rd2 = 32'h99; v.aluCtl = 4'd1; v.fwdB = 2'b01;
    v.resW = 32'h55; v.aluM = 32'h1234;
    e = mkE("fwdB_W", 1'b0, 1'b1, 32'hFFFF_FFB0, 1'b0, 32'h0);
    e.chkWd = 1'b1; e.wd = 32'h55;
    issue(v, e);
    // Select 11 behaves as register file; SRA sign-extends
    v = '0; v.rd1 = 32'h8000_0000; v.rd2 = 32'h4; v.aluCtl = 4'd9; v.fwdA = 2'b11;
    v.aluM = 32'h777;
    issue(v, mkE("sra_fwd11", 1'b0, 1'b1, 32'hF800_0000, 1'b0, 32'h0));
    // SRL uses only the low five shift bits
    v = '0; v.rd1 = 32'h8000_0000; v.rd2 = 32'h24; v.aluCtl = 4'd8;
    issue(v, mkE("srl", 1'b0, 1'b1, 32'h0800_0000, 1'b0, 32'h0));
    v = '0; v.rd1 = 32'h1; v.imm = 32'h3F; v.aluSrc = 1'b1; v.aluCtl = 4'd7;
    issue(v, mkE("sll", 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0));
    v = '0; v.rd1 = 32'hF0F0; v.rd2 = 32'h0FF0; v.aluCtl = 4'd4;
    issue(v, mkE("xor", 1'b0, 1'b1, 32'hFF00, 1'b0, 32'h0));
    v.aluCtl = 4'd3;
    issue(v, mkE("or", 1'b0, 1'b1, 32'hFFF0, 1'b0, 32'h0));
    v.aluCtl = 4'd2;
    issue(v, mkE("and", 1'b0, 1'b1, 32'h00F0, 1'b0, 32'h0));
    v = '0; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'h2;
    issue(v, mkE("add_wrap", 1'b0, 1'b1, 32'h1, 1'b0, 32'h0));
    // Reserved op gives 0, so a beq-style branch on it is taken
    v = '0; v.rd1 = 32'h5; v.rd2 = 32'h3; v.aluCtl = 4'd12; v.branch = 1'b1;
    v.pc = 32'h600; v.imm = 32'h40;
    issue(v, mkE("reserved", 1'b1, 1'b1, 32'h0, 1'b1, 32'h640));

    // Flush and stall together: flush wins, bubble cannot redirect or write
    driveFwd('0);
    v = '0; v.memWrite = 1'b1; v.regWrite = 1'b1; v.jump = 1'b1; v.branch = 1'b1;
    v.rd = 5'd7; v.rs1 = 5'd3; v.rs2 = 5'd4;
    driveD(v); FlushE = 1'b1; StallE = 1'b1;
    e = mkE("flush_stall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); e.chkCtl = 1'b1; e.cyc = cyc + 1;
    expQ.push_back(e);
    @(posedge clk); #1;
    FlushE = 1'b0; StallE = 1'b0;
    v = '0; v.regWrite = 1'b1; v.memWrite = 1'b1; v.resultSrc = 2'b01; v.rs1 = 5'd1;
    v.rs2 = 5'd2; v.rd = 5'd9; v.rd1 = 32'h30; v.rd2 = 32'h4; v.pc = 32'h500; v.imm = 32'h8;
    v.pcPlus4 = 32'h504;
    driveD(v);
    e = mkE("stall_load", 1'b0, 1'b1, 32'h34, 1'b1, 32'h508);
    e.chkCtl = 1'b1; e.regWrite = 1'b1; e.memWrite = 1'b1; e.resultSrc = 2'b01;
    e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd9; e.chkWd = 1'b1; e.wd = 32'h4; e.pcPlus4 = 32'h504;
    e.cyc = cyc + 1;
    expQ.push_back(e);
    @(posedge clk); #1;
    StallE = 1'b1;
    v = '0; v.jump = 1'b1; v.resultSrc = 2'b10; v.rd = 5'd31; v.rd1 = 32'h1; v.rd2 = 32'h1;
    v.pc = 32'h900; v.pcPlus4 = 32'h904;
    driveD(v);
    for (int i = 1; i <= 3; i++) begin
      e.name = $sformatf("stall_hold%0d", i);
      e.cyc  = cyc + i;
      expQ.push_back(e);
    end
    repeat (3) @(posedge clk);
    #1;
    // Reset during a stall: reset wins
    rst_n = 1'b0;
    e = mkE("rst_stall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); e.chkCtl = 1'b1; e.cyc = cyc + 1;
    expQ.push_back(e);
    @(posedge clk); #1;
    rst_n = 1'b1; StallE = 1'b0; driveD('0);
    repeat (2) @(posedge clk);
    #1;

    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk({e.name, ".unchecked"}, 32'(e.cyc), 32'(cyc));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipelined RV32I core. Captures decode-stage control and operand values in an ID/EX pipeline register with stall and flush, and applies operand forwarding selects from the hazard unit. Computes the ALU result and resolves branches and jumps, producing the PC redirect for fetch. Its outputs feed the EX/MEM register, which lives outside this block.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- FlushE  in  1  load a bubble into ID/EX at the next edge
- StallE  in  1  hold ID/EX contents
- RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, InverseBrCondD, LUIOpD  in  1 each  decode control
- ResultSrcD  in  2  00 ALU, 01 memory, 10 PC+4
- ALUControlD  in  4  ALU op (package encoding)
- RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  XLEN each  decode operands
- Rs1D, Rs2D, RdD  in  5 each  register indices
- ForwardAE, ForwardBE  in  2  00 register file, 01 ResultW, 10 ALUResultM, 11 treated as 00
- ResultW, ALUResultM  in  XLEN  forwarded values
- RegWriteE, MemWriteE  out  1  registered control to EX/MEM
- ResultSrcE  out  2  registered; bit 0 also goes to the hazard unit for load-use detection
- Rs1E, Rs2E, RdE  out  5  registered indices for hazard unit and EX/MEM
- ALUResultE, WriteDataE, PCPlus4E, PCTargetE  out  XLEN
- PCSrcE  out  1  redirect fetch to PCTargetE

## Operation
- ID/EX register update priority: rst_n low, then FlushE, then StallE, then load the D inputs.
- Reset and flush clear every control bit and every index to 0, making a bubble. Data fields reset to 0; on flush they may keep their old values.
- StallE holds all fields.
- SrcAE is 0 when LUIOpE = 1; otherwise it is the forward mux A output.
- Forward mux B output is WriteDataE.
- SrcBE is ImmExtE when ALUSrcE = 1; otherwise it is WriteDataE.
- ALU op encodings:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT (signed), 6 SLTU
  - 7 SLL, 8 SRL, 9 SRA, using shift amount SrcBE[4:0]
  - 10-15 reserved; result is 0
- ADD and SUB wrap modulo 2^XLEN.
- ZeroE = (ALUResultE == 0).
- Branch decision: BranchTakenE = BranchE & (ZeroE ^ InverseBrCondE).
  - The decoder pairs beq with SUB/inv 0 and bne with SUB/inv 1.
  - blt/bltu use SLT/SLTU with inv 1; bge/bgeu use SLT/SLTU with inv 0.
- PCSrcE = JumpE | BranchTakenE.
- PCTargetE = (ALUResultE & ~1) when JumpRegE = 1 (jalr); otherwise PCE + ImmExtE.

## Timing
- D inputs are sampled at the rising edge; all E outputs are valid in the following cycle.
- ALUResultE, PCTargetE and PCSrcE are combinational from ID/EX state and the forward inputs. There is no internal latency beyond the one register.
- After reset, every output control is 0 and PCSrcE = 0. No redirect or write may issue from a bubble.
- FlushE and StallE together: flush wins.
- rst_n low during a stall: reset wins.
- PCSrcE asserted in cycle N: the hazard unit raises FlushD/FlushE. The instruction captured at edge N+1 must be a bubble, with PCSrcE = 0 in cycle N+1.
- All paths must close in a single cycle. ALUResultM and ResultW feed the forwarding muxes combinationally.

## Structure
- Shared package `riscv_pkg`:
  - ALU op enum (4-bit)
  - ResultSrc enum (2-bit)
  - Forward-select enum (2-bit)
  - XLEN constant
- Sub-module `alu`: purely combinational, with ports SrcA, SrcB, ALUControl, ALUResult and Zero.
- The ID/EX register, forwarding muxes and branch/target logic stay in `ex_stage`.

## Test plan
- Reset: hold rst_n low 2 cycles with RegWriteD = 1 and JumpD = 1. Required: RegWriteE = 0, PCSrcE = 0 and RdE = 0 during reset and on the first cycle after release.
- beq/bne: RD1D = RD2D = 0x10, ALUControlD = SUB, BranchD = 1.
  - With InverseBrCondD = 0: PCSrcE = 1 and PCTargetE = PCD + ImmExtD (0x100 + 0x20 = 0x120).
  - With InverseBrCondD = 1: PCSrcE = 0.
- blt signed: RD1D = 0xFFFFFFFF, RD2D = 1, SLT, inv = 1. Required: PCSrcE = 1. The same operands with SLTU give PCSrcE = 0.
- jalr: RD1D = 0x1003, ImmExtD = 4, ADD, ALUSrcD = 1, JumpD = JumpRegD = 1. Required: PCTargetE = 0x1006 and PCSrcE = 1.
- Forwarding and LUI:
  - ForwardAE = 10 with ALUResultM = 7 and RD1D = 1, ADD with imm 3. Required: ALUResultE = 10.
  - LUIOpD = 1 with ImmExtD = 0x12345000. Required: ALUResultE = 0x12345000.
- Flush/stall priority: assert FlushE and StallE together with MemWriteD = 1. Required: MemWriteE = 0 next cycle. Then StallE alone: all E outputs hold for 3 cycles.
